// File: rtl/feed_forward_input_serializer_pkg.sv
// Shared types and constants for the feed-forward input serializer.
// Optional bias slot is selected by FF_SERIALIZER_BIAS_EN.
package feed_forward_input_serializer_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam logic [31:0] FP32_ONE = 32'h3F800000;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/feed_forward_input_serializer_weight_register_bank.sv
// Weight registers: one synchronous write port, one combinational read.
// Writes to slots at or above NUM_INPUTS are dropped.
module weight_register_bank
  import feed_forward_input_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_INPUTS = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH:0] SLOTS = (ADDR_WIDTH+1)'(NUM_INPUTS);

  logic [DATA_WIDTH-1:0] regs [NUM_INPUTS];
  logic                  hit;

  assign hit = wr_en && ({1'b0, wr_addr} < SLOTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        regs[i] <= '0;
    end else if (hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_idx} < SLOTS) ? regs[rd_idx] : '0;

endmodule

// File: rtl/feed_forward_input_serializer.sv
// Latches a parallel vector and streams word/weight pairs one per cycle.
// Define FF_SERIALIZER_BIAS_EN to force the last slot's data to 1.0.
module feed_forward_input_serializer
  import feed_forward_input_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_INPUTS = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data,
  output logic                             o_ready,
  input  logic                             i_weight_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_weight_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_weight_wr_data,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [DATA_WIDTH-1:0]            o_weight,
  output logic                             o_valid,
  output logic                             o_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_INPUTS-1);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d, idx;
  logic [DATA_WIDTH-1:0] vec    [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] in_vec [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] data_d, weight_d, rd_data;
  logic                  valid_d, last_d;
  logic                  accept, at_last;

  assign at_last = (state == STREAM) && (cnt == LAST);
  assign o_ready = (state == IDLE) || at_last;
  assign accept  = i_valid && o_ready;

  // Mid-vector the read index runs one ahead of cnt; on accept it is slot 0.
  assign idx = ((state == STREAM) && (cnt != LAST)) ? cnt + 1'b1 : '0;

  always_comb begin
    for (int k = 0; k < NUM_INPUTS; k++)
      in_vec[k] = i_data[DATA_WIDTH*k +: DATA_WIDTH];
`ifdef FF_SERIALIZER_BIAS_EN
    in_vec[NUM_INPUTS-1] = DATA_WIDTH'(FP32_ONE);
`endif
  end

`ifdef FF_SERIALIZER_BIAS_EN
  logic unused_top;
  assign unused_top = ^i_data[DATA_WIDTH*(NUM_INPUTS-1) +: DATA_WIDTH];
`endif

  weight_register_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_INPUTS(NUM_INPUTS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (i_weight_wr_en),
    .wr_addr(i_weight_wr_addr),
    .wr_data(i_weight_wr_data),
    .rd_idx (idx),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    data_d   = o_data;
    weight_d = o_weight;
    valid_d  = o_valid;
    last_d   = o_last;
    if (accept) begin
      state_d  = STREAM;
      cnt_d    = '0;
      data_d   = in_vec[0];
      weight_d = rd_data;
      valid_d  = 1'b1;
      last_d   = (LAST == '0);
    end else if (at_last) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (state == STREAM) begin
      cnt_d    = idx;
      data_d   = vec[idx];
      weight_d = rd_data;
      last_d   = (idx == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      o_data   <= '0;
      o_weight <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++)
        vec[k] <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      o_data   <= data_d;
      o_weight <= weight_d;
      o_valid  <= valid_d;
      o_last   <= last_d;
      if (accept) begin
        for (int k = 0; k < NUM_INPUTS; k++)
          vec[k] <= in_vec[k];
      end
    end
  end

endmodule

// File: tb/tb_feed_forward_input_serializer.sv
// Self-checking bench: protocol model plus expected-output queue.
// Honors FF_SERIALIZER_BIAS_EN for the last-slot data expectation.
module tb_feed_forward_input_serializer;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic [DW*N-1:0] i_data = '0;
  logic            o_ready;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [DW-1:0]   o_data;
  logic [DW-1:0]   o_weight;
  logic            o_valid;
  logic            o_last;

  always #5 clk = ~clk;

  feed_forward_input_serializer #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(N),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .o_ready         (o_ready),
    .i_weight_wr_en  (wr_en),
    .i_weight_wr_addr(wr_addr),
    .i_weight_wr_data(wr_data),
    .o_data          (o_data),
    .o_weight        (o_weight),
    .o_valid         (o_valid),
    .o_last          (o_last)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] w;
    logic        l;
  } exp_t;

  typedef struct {
    logic [DW*N-1:0] d;
    int              gap;
  } vec_t;

  exp_t        q[$];
  logic [31:0] w_m [N];
  int          slot_m = -1;
  int          total = 0;
  int          bad = 0;
  logic        acc = 1'b0;
  vec_t        tbl [4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] elem(input int k);
`ifdef FF_SERIALIZER_BIAS_EN
    if (k == N-1) return 32'h3F800000;
`endif
    return i_data[32*k +: 32];
  endfunction

  task automatic tick();
    exp_t e;
    logic rdy;
    @(negedge clk);
    rdy = (slot_m < 0) || (slot_m == N-1);
    chk("o_ready", 32'(o_ready), 32'(rdy));
    chk("o_valid", 32'(o_valid), 32'(slot_m >= 0));
    if (slot_m >= 0) begin
      if (q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("o_data", o_data, e.d);
        chk("o_weight", o_weight, e.w);
        chk("o_last", 32'(o_last), 32'(e.l));
      end
    end
    acc = i_valid && rdy;
    if (acc) begin
      for (int k = 0; k < N; k++)
        q.push_back('{elem(k), w_m[k], (k == N-1)});
      slot_m = 0;
    end else if (slot_m == N-1) begin
      slot_m = -1;
    end else if (slot_m >= 0) begin
      slot_m++;
    end
    if (wr_en && int'(wr_addr) < N) w_m[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [DW*N-1:0] d);
    i_valid = 1'b1;
    i_data = d;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{{32'h00000000, 32'h7F800000, 32'h80000000}, 1};
    tbl[1] = '{{32'hFFFFFFFF, 32'h00000001, 32'hAAAA5555}, 0};
    tbl[2] = '{{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F}, 3};
    tbl[3] = '{{32'h7FC00000, 32'hC0490FDB, 32'h3DCCCCCD}, 2};
    for (int k = 0; k < N; k++) w_m[k] = '0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_o_ready", 32'(o_ready), 32'd1);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_o_weight", o_weight, 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    idle(1);

    wr(2'd0, 32'h3F800000);
    wr(2'd1, 32'h40000000);
    wr(2'd2, 32'h40400000);
    wr(2'd3, 32'hDEADBEEF);
    send({32'hBF800000, 32'h3E800000, 32'h3F000000});
    idle(4);

    for (int v = 0; v < 4; v++) begin
      send(tbl[v].d);
      idle(tbl[v].gap);
    end
    idle(4);

    send({32'h11111113, 32'h11111112, 32'h11111111});
    send({32'h22222223, 32'h22222222, 32'h22222221});
    idle(4);

    send({32'h33333333, 32'h33333332, 32'h33333331});
    i_valid = 1'b1;
    i_data = {32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE};
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 32'h41000000;
    tick();
    i_valid = 1'b0;
    wr_en = 1'b0;
    idle(3);
    send({32'h44444443, 32'h44444442, 32'h44444441});
    chk("collision_model_w1", w_m[1], 32'h41000000);
    idle(4);

    send({32'h55555553, 32'h55555552, 32'h55555551});
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_o_data", o_data, 32'd0);
    chk("mid_rst_o_weight", o_weight, 32'd0);
    chk("mid_rst_o_last", 32'(o_last), 32'd0);
    chk("mid_rst_o_ready", 32'(o_ready), 32'd1);
    q.delete();
    slot_m = -1;
    for (int k = 0; k < N; k++) w_m[k] = '0;
    #1 rst_n = 1'b1;
    send({32'h66666663, 32'h66666662, 32'h66666661});
    idle(4);

    wr(2'd0, 32'h3F000000);
    wr(2'd1, 32'h3E000000);
    wr(2'd2, 32'hC1200000);
    send({32'h12345678, 32'h40A00000, 32'h40800000});
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feed_forward_input_serializer.md
Name: feed_forward_input_serializer

Overview:
- Upstream feeder for the input-layer feed-forward node.
- Latches one parallel input vector of NUM_INPUTS float32 words and streams it one word per cycle.
- Each data word is paired with its weight from a local writable weight register bank.
- The stream drives the node's i_data, i_weight and i_valid, and is sized to match the node's 3-input serial accumulator.

Parameters:
- DATA_WIDTH, 32, word width in bits (IEEE-754 single).
- NUM_INPUTS, 3, words per vector; must equal the downstream adder input count.
- ADDR_WIDTH, 2, weight-bank address width; 2**ADDR_WIDTH >= NUM_INPUTS.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- i_valid, input, 1, input vector present on i_data.
- i_data, input, DATA_WIDTH*NUM_INPUTS, element k at bits [DATA_WIDTH*k +: DATA_WIDTH].
- o_ready, output, 1, block accepts a vector this cycle.
- i_weight_wr_en, input, 1, weight write strobe.
- i_weight_wr_addr, input, ADDR_WIDTH, weight slot to write.
- i_weight_wr_data, input, DATA_WIDTH, weight value.
- o_data, output, DATA_WIDTH, serialized data word.
- o_weight, output, DATA_WIDTH, weight paired with o_data.
- o_valid, output, 1, o_data and o_weight valid.
- o_last, output, 1, final word of the current vector.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, cnt=0, vector regs=0, all weights=0, o_data=0, o_weight=0, o_valid=0, o_last=0. o_ready=1 after reset.
- FSM states:
  - IDLE -> STREAM on accept.
  - STREAM -> IDLE when cnt==NUM_INPUTS-1 and there is no accept.
  - STREAM -> STREAM (cnt reset to 0) when cnt==NUM_INPUTS-1 and there is an accept.
- o_ready (combinational) = (state==IDLE) || (state==STREAM && cnt==NUM_INPUTS-1).
- Accept = i_valid && o_ready, sampled on the clk edge.
- On accept, the whole vector is latched and, on the same edge, o_data<=element 0, o_weight<=w[0], o_valid<=1, o_last<=(NUM_INPUTS==1).
- Latency: 1 cycle from accept to first o_valid.
- Each following edge in STREAM increments cnt and presents element cnt with w[cnt]; o_last=1 exactly when cnt==NUM_INPUTS-1.
- Throughput: an accept in the last STREAM cycle gives a gapless back-to-back stream, so o_valid stays 1 and element 0 of the new vector follows immediately.
- When the FSM returns to IDLE: o_valid<=0 and o_last<=0. o_data and o_weight hold their last values.
- i_valid while o_ready=0: ignored. No buffering, no error flag; the upstream must honour o_ready.
- Weight writes:
  - Accepted in any state.
  - A write to the slot being read on the same edge outputs the old value; the new value is used from the next read.
  - Addresses >= NUM_INPUTS are ignored.
- rst_n asserted mid-stream: outputs clear immediately (asynchronous reset) and the partial vector is discarded.
- No arithmetic is performed in this block; words pass through bit-exact.

Optional Feature:
- Macro: FF_SERIALIZER_BIAS_EN.
- Defined: the last stream slot (index NUM_INPUTS-1) always outputs o_data=32'h3F800000 (1.0), and w[NUM_INPUTS-1] acts as the node bias. The top word of i_data is ignored.
- Undefined: all NUM_INPUTS words come from i_data.

Decomposition:
- Shared package holds:
  - FP32_ONE = 32'h3F800000.
  - State encoding IDLE/STREAM.
  - Default DATA_WIDTH.
- One sub-module: weight_register_bank, with NUM_INPUTS x DATA_WIDTH registers, async reset to 0, one synchronous write port and one combinational read by index.

Test Plan:
- Reset then idle: after rst_n release, o_ready=1, o_valid=0, o_data=0, o_weight=0.
- Single vector: write w = {3F800000, 40000000, 40400000}, apply i_data elements {3F000000, 3E800000, BF800000} with one i_valid pulse. Required over the next 3 cycles: (3F000000,3F800000), (3E800000,40000000), (BF800000,40400000). o_last only on the 3rd; o_valid=0 on the 4th.
- Back-to-back: hold i_valid high across two vectors. Required: 6 consecutive o_valid cycles, o_ready low on the first two cycles of each vector, o_last on cycles 3 and 6.
- Ignored input and write collision: pulse i_valid during stream cycle 1, and write w[1]=41000000 on the edge that reads slot 1. Required: the stray i_valid is dropped; this stream outputs the old w[1], and the next vector outputs 41000000 in slot 1.
- Reset mid-stream: assert rst_n during cycle 2 of a stream. Required: all outputs 0 immediately, weights 0. The next accepted vector streams from element 0.
- FF_SERIALIZER_BIAS_EN defined: i_data top word = 12345678. Required: slot 2 outputs o_data=3F800000 with o_weight=w[2].
